aes_encrypt_stream: RTL and testbench

//  Parametrised, iterative AES encryption engine: AES-128/192/256 and 1-8 byte bus beats.
//  Key expansion runs on the fly, one word per cycle; there is no stored key schedule.
//  A valid/ready stream handshake replaces the fixed load/ready strobes.

---
 rtl/aes_encrypt_stream.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_aes_encrypt_stream.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_stream.sv
`default_nettype none
// ============================================================================
// Module      : aes_encrypt_stream
// Description : Iterative AES-128/192/256 encryption engine with valid/ready
//               byte-stream input and ciphertext output. The key schedule is
//               expanded on the fly, one word per cycle, from a stored key.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_encrypt_stream #(
    parameter int BUS_BYTES = 1,
    parameter int KEY_BITS  = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BUS_BYTES*8-1:0] in_data,
    input  logic                   in_key,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BUS_BYTES*8-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int W         = BUS_BYTES * 8;
    localparam int NK        = KEY_BITS / 32;
    localparam int NR        = NK + 6;
    localparam int KEY_BEATS = KEY_BITS / W;
    localparam int ST_BEATS  = 16 / BUS_BYTES;

    localparam logic [5:0] KEY_LAST = 6'(KEY_BEATS - 1);
    localparam logic [5:0] ST_LAST  = 6'(ST_BEATS - 1);
    localparam logic [5:0] NK_W     = 6'(NK);
    localparam logic [2:0] NK_LAST  = 3'(NK - 1);
    localparam logic [3:0] NR_L     = 4'(NR);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_LOAD_ST  = 3'd2,
        S_RUN      = 3'd3,
        S_OUT      = 3'd4
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX_TBL[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte n of the state sits at bits [127-8n -: 8], n = row + 4*column.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [KEY_BITS-1:0] key_q;
    logic [127:0]        st_q;
    logic [127:0]        rk_q;
    logic [7:0][31:0]    win_q;     // win_q[0] = w[i-1], win_q[j] = w[i-1-j]
    logic [5:0]          beat_q;
    logic [2:0]          cyc_q;
    logic [3:0]          slot_q;
    logic [5:0]          widx_q;    // word index i being generated
    logic [2:0]          wmod_q;    // i mod Nk, kept as a wrapping counter
    logic [7:0]          rcon_q;
    logic                prime_q;   // first RUN cycle restarts the schedule

    logic                w_in_acc;
    logic                w_out_acc;
    logic [127:0]        w_sub;
    logic [127:0]        w_sr;
    logic [127:0]        w_round;
    logic [31:0]         w_kin;
    logic [31:0]         w_ksub;
    logic [31:0]         w_key_word;
    logic [31:0]         w_new;

    assign w_in_acc  = in_valid && in_ready;
    assign w_out_acc = out_valid && out_ready;

    for (genvar b = 0; b < 16; b++) begin : g_sbox_data
        assign w_sub[127-8*b -: 8] = sbox(st_q[127-8*b -: 8]);
    end

    for (genvar k = 0; k < 4; k++) begin : g_sbox_key
        assign w_ksub[31-8*k -: 8] = sbox(w_kin[31-8*k -: 8]);
    end

    // Next key-schedule word from the sliding window.
    always_comb begin
        w_key_word = key_q[KEY_BITS-1-32*int'(wmod_q) -: 32];
        w_kin      = (wmod_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];
        if (widx_q < NK_W) begin
            w_new = w_key_word;
        end else if (wmod_q == 3'd0) begin
            w_new = win_q[NK-1] ^ w_ksub ^ {rcon_q, 24'h0};
        end else if ((NK == 8) && (wmod_q == 3'd4)) begin
            w_new = win_q[NK-1] ^ w_ksub;
        end else begin
            w_new = win_q[NK-1] ^ win_q[0];
        end
    end

    // Round transform selected by the slot number.
    always_comb begin
        w_sr = shift_rows(w_sub);
        if (slot_q == 4'd0) begin
            w_round = st_q ^ rk_q;
        end else if (slot_q == NR_L) begin
            w_round = w_sr ^ rk_q;
        end else begin
            w_round = mix_columns(w_sr) ^ rk_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = rst;
                if (in_valid && rst) begin
                    state_d = in_key ? S_LOAD_KEY : S_LOAD_ST;
                end
            end
            S_LOAD_KEY: begin
                in_ready = rst;
                if (in_valid && rst && (beat_q == KEY_LAST)) begin
                    state_d = S_LOAD_ST;
                end
            end
            S_LOAD_ST: begin
                in_ready = rst;
                if (in_valid && rst && (beat_q == ST_LAST)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!prime_q && (cyc_q == 3'd4) && (slot_q == NR_L)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = st_q[127 -: W];
                out_last  = (beat_q == ST_LAST);
                if (out_ready && (beat_q == ST_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy    = 1'b0;
            end
        endcase
    end

    // Load shifting, key expansion, round application and output shifting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_q   <= '0;
            st_q    <= '0;
            rk_q    <= '0;
            win_q   <= '0;
            beat_q  <= '0;
            cyc_q   <= '0;
            slot_q  <= '0;
            widx_q  <= '0;
            wmod_q  <= '0;
            rcon_q  <= 8'h01;
            prime_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_in_acc) begin
                        beat_q <= 6'd1;
                        if (in_key) begin
                            key_q <= {key_q[KEY_BITS-W-1:0], in_data};
                        end else begin
                            st_q <= {st_q[127-W:0], in_data};
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (w_in_acc) begin
                        key_q  <= {key_q[KEY_BITS-W-1:0], in_data};
                        beat_q <= (beat_q == KEY_LAST) ? 6'd0 : beat_q + 6'd1;
                    end
                end
                S_LOAD_ST: begin
                    if (w_in_acc) begin
                        st_q <= {st_q[127-W:0], in_data};
                        if (beat_q == ST_LAST) begin
                            beat_q  <= 6'd0;
                            prime_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 6'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (prime_q) begin
                        prime_q <= 1'b0;
                        cyc_q   <= 3'd0;
                        slot_q  <= 4'd0;
                        widx_q  <= 6'd0;
                        wmod_q  <= 3'd0;
                        rcon_q  <= 8'h01;
                    end else if (cyc_q != 3'd4) begin
                        win_q  <= {win_q[6:0], w_new};
                        rk_q   <= {rk_q[95:0], w_new};
                        widx_q <= widx_q + 6'd1;
                        wmod_q <= (wmod_q == NK_LAST) ? 3'd0 : wmod_q + 3'd1;
                        if ((widx_q >= NK_W) && (wmod_q == 3'd0)) begin
                            rcon_q <= xtime(rcon_q);
                        end
                        cyc_q <= cyc_q + 3'd1;
                    end else begin
                        st_q   <= w_round;
                        cyc_q  <= 3'd0;
                        slot_q <= slot_q + 4'd1;
                    end
                end
                S_OUT: begin
                    if (w_out_acc) begin
                        st_q   <= {st_q[127-W:0], {W{1'b0}}};
                        beat_q <= (beat_q == ST_LAST) ? 6'd0 : beat_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_encrypt_stream
// Description : Bench for aes_encrypt_stream covering AES-128/192/256 across
//               bus widths 1, 4 and 8 bytes, key reuse, backpressure, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_encrypt_stream;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CTZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_key;
    logic        in_valid;
    logic        out_ready;
    int          sel;
    int          bus;
    int          cyc = 0;
    int          acc_cyc;
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];

    logic        va, vb, vc;
    logic        ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, ol_a, ol_b, ol_c, bz_a, bz_b, bz_c;
    logic [7:0]  od_a;
    logic [31:0] od_b;
    logic [63:0] od_c;
    logic        obs_in_ready, obs_out_valid, obs_out_last, obs_busy;
    logic [63:0] obs_out_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign va = in_valid && (sel == 0);
    assign vb = in_valid && (sel == 1);
    assign vc = in_valid && (sel == 2);

    aes_encrypt_stream #(.BUS_BYTES(1), .KEY_BITS(128)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_key(in_key), .in_valid(va),
        .in_ready(ir_a), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_last(ol_a), .busy(bz_a));

    aes_encrypt_stream #(.BUS_BYTES(4), .KEY_BITS(192)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data[31:0]), .in_key(in_key), .in_valid(vb),
        .in_ready(ir_b), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_last(ol_b), .busy(bz_b));

    aes_encrypt_stream #(.BUS_BYTES(8), .KEY_BITS(256)) u_c (
        .clk(clk), .rst(rst), .in_data(in_data), .in_key(in_key), .in_valid(vc),
        .in_ready(ir_c), .out_data(od_c), .out_valid(ov_c), .out_ready(out_ready),
        .out_last(ol_c), .busy(bz_c));

    always_comb begin
        obs_in_ready  = ir_a;
        obs_out_valid = ov_a;
        obs_out_last  = ol_a;
        obs_busy      = bz_a;
        obs_out_data  = {56'h0, od_a};
        if (sel == 1) begin
            obs_in_ready  = ir_b;
            obs_out_valid = ov_b;
            obs_out_last  = ol_b;
            obs_busy      = bz_b;
            obs_out_data  = {32'h0, od_b};
        end else if (sel == 2) begin
            obs_in_ready  = ir_c;
            obs_out_valid = ov_c;
            obs_out_last  = ol_c;
            obs_busy      = bz_c;
            obs_out_data  = od_c;
        end
    end

    // Drive one block; expected ciphertext beats go to the scoreboard.
    task automatic send_block(input logic [255:0] key, input int kbits, input bit use_key,
                              input logic [127:0] pt, input logic [127:0] ct,
                              input bit key_on_b1, input int stall_at);
        logic [7:0]  bytes[$];
        logic [63:0] beat;
        int          nbeats;
        int          guard;
        if (use_key) begin
            for (int i = 0; i < kbits/8; i++) bytes.push_back(key[255-8*i -: 8]);
        end
        for (int i = 0; i < 16; i++) bytes.push_back(pt[127-8*i -: 8]);
        for (int k = 0; k < 16/bus; k++) begin
            beat = '0;
            for (int j = 0; j < bus; j++) beat = (beat << 8) | 64'(ct[127-8*(k*bus+j) -: 8]);
            exp_q.push_back(beat);
        end
        nbeats = bytes.size() / bus;
        for (int n = 0; n < nbeats; n++) begin
            @(negedge clk);
            if (n == stall_at) begin
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            beat = '0;
            for (int j = 0; j < bus; j++) beat = (beat << 8) | 64'(bytes[n*bus+j]);
            in_data  = beat;
            in_key   = (n == 0) ? use_key : ((n == 1) && key_on_b1);
            in_valid = 1'b1;
            guard = 0;
            while (!obs_in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!obs_in_ready) begin
                total++; bad++;
                $display("FAIL in_ready_timeout: got %b want 1 (beat %0d)", obs_in_ready, n);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
    endtask

    // Collect one block, checking latency, data, out_last and busy.
    task automatic recv_block(input int lat_exp, input int bp_cycles, input string name);
        int          guard;
        int          nb;
        logic [63:0] exp;
        nb = 16 / bus;
        guard = 0;
        @(negedge clk);
        while (!obs_out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        total++;
        if (!obs_out_valid) begin
            bad++;
            $display("FAIL %s_out_timeout: got %b want 1", name, obs_out_valid);
            return;
        end
        if (cyc - acc_cyc !== lat_exp) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, cyc - acc_cyc, lat_exp);
        end
        for (int k = 0; k < nb; k++) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL %s_scoreboard_empty: got 0 entries want 1", name);
                return;
            end
            if (k == 0 && bp_cycles > 0) begin
                out_ready = 1'b0;
                repeat (bp_cycles) begin
                    @(negedge clk);
                    total++;
                    if (obs_out_valid !== 1'b1 || obs_busy !== 1'b1 || obs_out_data !== exp_q[0]) begin
                        bad++;
                        $display("FAIL %s_stall: got v=%b busy=%b d=%h want v=1 busy=1 d=%h",
                                 name, obs_out_valid, obs_busy, obs_out_data, exp_q[0]);
                    end
                end
            end
            exp = exp_q.pop_front();
            total++;
            if (obs_out_valid !== 1'b1 || obs_out_data !== exp) begin
                bad++;
                $display("FAIL %s_data%0d: got v=%b d=%h want v=1 d=%h", name, k, obs_out_valid, obs_out_data, exp);
            end
            total++;
            if (obs_out_last !== (k == nb-1)) begin
                bad++;
                $display("FAIL %s_last%0d: got %b want %b", name, k, obs_out_last, (k == nb-1));
            end
            total++;
            if (obs_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s_busy%0d: got %b want 1", name, k, obs_busy);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
        end
        total++;
        if (obs_busy !== 1'b0 || obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_end: got busy=%b v=%b rdy=%b want busy=0 v=0 rdy=1",
                     name, obs_busy, obs_out_valid, obs_in_ready);
        end
    endtask

    task automatic test_reset();
        sel = 0; bus = 1;
        rst = 1'b0; in_valid = 1'b0; in_key = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", obs_in_ready); end
        total++;
        if (obs_out_valid !== 1'b0 || obs_out_last !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid: got v=%b l=%b want 0 0", obs_out_valid, obs_out_last);
        end
        total++;
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", obs_busy); end
        total++;
        if (obs_out_data !== 64'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", obs_out_data); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", obs_in_ready); end
    endtask

    task automatic test_aes128();
        sel = 0; bus = 1;
        send_block(KEY1, 128, 1'b1, PT, CT1, 1'b0, -1);
        recv_block(56, 0, "aes128");
    endtask

    task automatic test_aes192();
        sel = 1; bus = 4;
        send_block(KEY2, 192, 1'b1, PT, CT2, 1'b0, 3);
        recv_block(66, 0, "aes192");
    endtask

    task automatic test_aes256();
        sel = 2; bus = 8;
        send_block(KEY3, 256, 1'b1, PT, CT3, 1'b0, -1);
        recv_block(76, 0, "aes256");
    endtask

    task automatic test_key_reuse();
        sel = 0; bus = 1;
        send_block(256'h0, 128, 1'b0, PT, CT1, 1'b1, -1);
        // Beats offered while the engine runs must be ignored.
        in_data = '1; in_key = 1'b1; in_valid = 1'b1;
        recv_block(56, 0, "reuse");
    endtask

    task automatic test_backpressure();
        sel = 0; bus = 1;
        send_block(256'h0, 128, 1'b0, PT, CT1, 1'b0, -1);
        recv_block(56, 10, "bp");
    endtask

    task automatic test_reset_mid_run();
        sel = 0; bus = 1;
        send_block(KEY1, 128, 1'b1, PT, CT1, 1'b0, -1);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        total++;
        if (obs_busy !== 1'b1 || obs_out_valid !== 1'b0) begin
            bad++; $display("FAIL midrun_busy: got busy=%b v=%b want 1 0", obs_busy, obs_out_valid);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total++;
        if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: got v=%b rdy=%b busy=%b want 0 1 0", obs_out_valid, obs_in_ready, obs_busy);
        end
        send_block(256'h0, 128, 1'b0, 128'h0, CTZ, 1'b0, -1);
        recv_block(56, 0, "zerokey");
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_key_reuse();
        test_backpressure();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
